// File: rtl/deflate_pkg.sv
// Shared constants, types and helpers for the fixed-Huffman (BTYPE=01) DEFLATE packer.
package deflate_pkg;

  localparam int unsigned MAX_CHUNK_BITS = 30;
  localparam int unsigned ACC_W          = 64;
  localparam int unsigned WORD_W         = 32;

  localparam logic [1:0] BTYPE_FIXED = 2'b01;
  localparam logic [8:0] SYM_END     = 9'd256;

  // Fixed literal/length table bands: last symbol of each band, code base, code length
  localparam logic [8:0] LL_BAND0_LAST = 9'd143;
  localparam logic [8:0] LL_BAND1_LAST = 9'd255;
  localparam logic [8:0] LL_BAND2_LAST = 9'd279;
  localparam logic [8:0] LL_BAND0_BASE = 9'h030;
  localparam logic [8:0] LL_BAND1_BASE = 9'h190;
  localparam logic [8:0] LL_BAND3_BASE = 9'h0C0;
  localparam logic [8:0] LL_BAND1_FIRST = 9'd144;
  localparam logic [8:0] LL_BAND3_FIRST = 9'd280;
  localparam logic [3:0] LL_BAND0_LEN  = 4'd8;
  localparam logic [3:0] LL_BAND1_LEN  = 4'd9;
  localparam logic [3:0] LL_BAND2_LEN  = 4'd7;
  localparam logic [3:0] LL_BAND3_LEN  = 4'd8;

  localparam logic [4:0] DIST_CODE_LEN = 5'd5;
  localparam logic [4:0] END_CODE_LEN  = 5'd7;
  localparam logic [4:0] HDR_LEN       = 5'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } pk_state_t;

  // One stage-1 entry: LSB-first bit chunk, its length, and end-of-final-block marker
  typedef struct packed {
    logic [MAX_CHUNK_BITS-1:0] bits;
    logic [4:0]                nbits;
    logic                      last;
  } chunk_t;

  // Reverse the low 'len' bits of a Huffman code so its MSB goes out first
  function automatic logic [8:0] bitrev(input logic [8:0] code, input logic [3:0] len);
    logic [8:0] r;
    r = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      r[i] = code[8-i];
    end
    return r >> (4'd9 - len);
  endfunction

endpackage

// File: rtl/fixed_huffman_code_lut.sv
// Combinational fixed-table lookup: lit/len symbol and distance symbol to
// bit-reversed Huffman codes ready for LSB-first packing.
module fixed_huffman_code_lut
  import deflate_pkg::*;
(
  input  logic [8:0] symbol,
  input  logic [4:0] dist_symbol,
  output logic [8:0] ll_code_rev,
  output logic [3:0] ll_len,
  output logic [4:0] dist_code_rev
);

  logic [8:0] ll_code;

  // Select the lit/len band, form the canonical code, then reverse it
  always_comb begin
    ll_code = '0;
    ll_len  = LL_BAND0_LEN;
    if (symbol <= LL_BAND0_LAST) begin
      ll_code = LL_BAND0_BASE + symbol;
      ll_len  = LL_BAND0_LEN;
    end else if (symbol <= LL_BAND1_LAST) begin
      ll_code = LL_BAND1_BASE + (symbol - LL_BAND1_FIRST);
      ll_len  = LL_BAND1_LEN;
    end else if (symbol <= LL_BAND2_LAST) begin
      ll_code = symbol - SYM_END;
      ll_len  = LL_BAND2_LEN;
    end else begin
      ll_code = LL_BAND3_BASE + (symbol - LL_BAND3_FIRST);
      ll_len  = LL_BAND3_LEN;
    end
    ll_code_rev = bitrev(ll_code, ll_len);
  end

  // Distance codes are a flat 5-bit code equal to the symbol
  always_comb begin
    dist_code_rev = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      dist_code_rev[i] = dist_symbol[4-i];
    end
  end

endmodule

// File: rtl/fixed_huffman_bit_packer.sv
// DEFLATE fixed-Huffman bit packer: block headers, symbols and END codes are
// turned into bit chunks (S1), merged into a 64-bit accumulator (S2) and
// emitted LSB-first as 32-bit words, with a byte-padded flush on the final block.
module fixed_huffman_bit_packer
  import deflate_pkg::*;
#(
  parameter bit CHECK_EXCL = 1'b1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_final,
  input  logic        i_end,
  input  logic        i_symbol_en,
  input  logic [8:0]  i_symbol,
  input  logic [4:0]  i_len_ebits,
  input  logic [2:0]  i_len_ecnt,
  input  logic [4:0]  i_dist_symbol,
  input  logic [11:0] i_dist_ebits,
  input  logic [3:0]  i_dist_ecnt,
  output logic        o_en,
  output logic [31:0] o_data,
  output logic [2:0]  o_byte_cnt,
  output logic        o_last
);

  pk_state_t state_q, state_d;
  logic      final_q, final_d;

  logic [8:0] ll_code_rev;
  logic [3:0] ll_len;
  logic [4:0] dist_code_rev;

  logic [4:0]  le_mask;
  logic [11:0] de_mask;
  logic [4:0]  off_le, off_dc, off_de;
  chunk_t      sym_chunk;

  chunk_t s1_d, s1_q;
  logic   s1_valid_d, s1_valid_q;

  logic [ACC_W-1:0] acc_q, acc_d, merged;
  logic [5:0]       cnt_q, cnt_d, sum;

  logic        en_d, last_d;
  logic [31:0] data_d;
  logic [2:0]  bcnt_d;

  fixed_huffman_code_lut u_lut (
    .symbol        (i_symbol),
    .dist_symbol   (i_dist_symbol),
    .ll_code_rev   (ll_code_rev),
    .ll_len        (ll_len),
    .dist_code_rev (dist_code_rev)
  );

  // Assemble one symbol's chunk: litlen code, len extra, dist code, dist extra
  always_comb begin
    le_mask   = (5'd1 << i_len_ecnt) - 5'd1;
    de_mask   = (12'd1 << i_dist_ecnt) - 12'd1;
    off_le    = {1'b0, ll_len};
    off_dc    = off_le + {2'b00, i_len_ecnt};
    off_de    = off_dc + DIST_CODE_LEN;
    sym_chunk = '0;
    if (i_symbol > SYM_END) begin
      sym_chunk.bits  = MAX_CHUNK_BITS'(ll_code_rev)
                      | (MAX_CHUNK_BITS'(i_len_ebits & le_mask) << off_le)
                      | (MAX_CHUNK_BITS'(dist_code_rev) << off_dc)
                      | (MAX_CHUNK_BITS'(i_dist_ebits & de_mask) << off_de);
      sym_chunk.nbits = off_de + {1'b0, i_dist_ecnt};
    end else begin
      sym_chunk.bits  = MAX_CHUNK_BITS'(ll_code_rev);
      sym_chunk.nbits = off_le;
    end
  end

  // Block FSM and S1 chunk selection; priority start > end > symbol
  always_comb begin
    state_d    = state_q;
    final_d    = final_q;
    s1_valid_d = 1'b0;
    s1_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_ACTIVE;
          final_d    = i_final;
          s1_valid_d = 1'b1;
          s1_d.bits  = MAX_CHUNK_BITS'({BTYPE_FIXED, i_final});
          s1_d.nbits = HDR_LEN;
        end
      end
      ST_ACTIVE: begin
        // A start here is illegal and wins priority, so it swallows the cycle
        if (!i_start) begin
          if (i_end) begin
            s1_valid_d = 1'b1;
            s1_d.nbits = END_CODE_LEN;
            s1_d.last  = final_q;
            state_d    = final_q ? ST_FLUSH : ST_IDLE;
          end else if (i_symbol_en) begin
            s1_valid_d = 1'b1;
            s1_d       = sym_chunk;
          end
        end
      end
      ST_FLUSH: begin
        // END has been merged once S1 drains; the pad/emit happens on this edge
        if (!s1_valid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // S2: merge S1 chunk at bit cnt, peel off full words, pad-and-flush at block end
  always_comb begin
    merged = acc_q | (ACC_W'(s1_q.bits) << cnt_q);
    sum    = cnt_q + {1'b0, s1_q.nbits};
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    en_d   = 1'b0;
    data_d = '0;
    bcnt_d = '0;
    last_d = 1'b0;
    if (s1_valid_q) begin
      if (sum >= 6'(WORD_W)) begin
        en_d   = 1'b1;
        data_d = merged[WORD_W-1:0];
        bcnt_d = 3'd4;
        last_d = s1_q.last && (sum == 6'(WORD_W));
        acc_d  = merged >> WORD_W;
        cnt_d  = sum - 6'(WORD_W);
      end else begin
        acc_d = merged;
        cnt_d = sum;
      end
    end else if (state_q == ST_FLUSH && cnt_q != '0) begin
      en_d   = 1'b1;
      data_d = acc_q[WORD_W-1:0];
      bcnt_d = 3'((cnt_q + 6'd7) >> 3);
      last_d = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end
  end

  // State, S1, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      final_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      o_en       <= 1'b0;
      o_data     <= '0;
      o_byte_cnt <= '0;
      o_last     <= 1'b0;
    end else begin
      state_q    <= state_d;
      final_q    <= final_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      o_en       <= en_d;
      o_data     <= data_d;
      o_byte_cnt <= bcnt_d;
      o_last     <= last_d;
    end
  end

  generate
    if (CHECK_EXCL) begin : g_excl
      a_excl: assert property (@(posedge clk) disable iff (rst)
                               $onehot0({i_start, i_end, i_symbol_en}));
    end
  endgenerate

endmodule

// File: tb/tb_fixed_huffman_bit_packer.sv
// Directed bench for fixed_huffman_bit_packer with a bit-queue reference model.
module tb_fixed_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_final = 1'b0, i_end = 1'b0, i_symbol_en = 1'b0;
  logic [8:0]  i_symbol = '0;
  logic [4:0]  i_len_ebits = '0;
  logic [2:0]  i_len_ecnt = '0;
  logic [4:0]  i_dist_symbol = '0;
  logic [11:0] i_dist_ebits = '0;
  logic [3:0]  i_dist_ecnt = '0;
  logic        o_en;
  logic [31:0] o_data;
  logic [2:0]  o_byte_cnt;
  logic        o_last;

  always #5 clk = ~clk;

  fixed_huffman_bit_packer #(.CHECK_EXCL(1'b0)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_final(i_final), .i_end(i_end),
    .i_symbol_en(i_symbol_en), .i_symbol(i_symbol), .i_len_ebits(i_len_ebits),
    .i_len_ecnt(i_len_ecnt), .i_dist_symbol(i_dist_symbol), .i_dist_ebits(i_dist_ebits),
    .i_dist_ecnt(i_dist_ecnt), .o_en(o_en), .o_data(o_data), .o_byte_cnt(o_byte_cnt),
    .o_last(o_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: stream bits in order, cut into 32-bit words
  bit          bq[$];
  logic [31:0] ex_data[$];
  int          ex_bc[$];
  bit          ex_last[$];
  int          m_open = 0;
  bit          m_final = 1'b0;

  // Log of every word the DUT produced
  logic [31:0] lg_data[$];
  int          lg_bc[$];
  bit          lg_last[$];
  int          lg_cyc[$];

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_bits(logic [31:0] v, int n, bit msb_first);
    for (int i = 0; i < n; i++) bq.push_back(msb_first ? v[n-1-i] : v[i]);
  endfunction

  function automatic void cut_words(bit final_end);
    logic [31:0] w;
    int n;
    while (bq.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
      ex_data.push_back(w); ex_bc.push_back(4); ex_last.push_back(1'b0);
    end
    if (final_end) begin
      if (bq.size() == 0) begin
        if (ex_last.size() > 0) ex_last[ex_last.size()-1] = 1'b1;
      end else begin
        n = bq.size();
        w = '0;
        for (int i = 0; i < n; i++) w[i] = bq.pop_front();
        ex_data.push_back(w); ex_bc.push_back((n + 7) / 8); ex_last.push_back(1'b1);
      end
    end
  endfunction

  function automatic void model_event(bit st, bit fin, bit en, bit se, int sym,
                                      int leb, int lec, int ds, int deb, int dec);
    int code, len;
    if (st) begin
      if (m_open == 0) begin
        push_bits(fin, 1, 0); push_bits(1, 1, 0); push_bits(0, 1, 0);
        m_open = 1; m_final = fin;
      end
    end else if (en) begin
      if (m_open == 1) begin
        push_bits(0, 7, 1);
        m_open = 0;
        cut_words(m_final);
      end
    end else if (se && m_open == 1) begin
      if (sym <= 143)      begin code = 'h30 + sym;         len = 8; end
      else if (sym <= 255) begin code = 'h190 + sym - 144;  len = 9; end
      else if (sym <= 279) begin code = sym - 256;          len = 7; end
      else                 begin code = 'hC0 + sym - 280;   len = 8; end
      push_bits(code, len, 1);
      if (sym >= 257) begin
        push_bits(leb, lec, 0);
        push_bits(ds, 5, 1);
        push_bits(deb, dec, 0);
      end
      cut_words(1'b0);
    end
  endfunction

  task automatic drive(bit st, bit fin, bit en, bit se, int sym,
                       int leb, int lec, int ds, int deb, int dec);
    @(posedge clk); #1;
    i_start = st; i_final = fin; i_end = en; i_symbol_en = se;
    i_symbol = 9'(sym); i_len_ebits = 5'(leb); i_len_ecnt = 3'(lec);
    i_dist_symbol = 5'(ds); i_dist_ebits = 12'(deb); i_dist_ecnt = 4'(dec);
    drv_cyc = cyc;
    model_event(st, fin, en, se, sym, leb, lec, ds, deb, dec);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_start = 0; i_final = 0; i_end = 0; i_symbol_en = 0;
    end
  endtask

  task automatic start_blk(bit fin); drive(1, fin, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic end_blk();          drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lit(int v);         drive(0, 0, 0, 1, v, 0, 0, 0, 0, 0); endtask
  task automatic sym(int s, int leb, int lec, int ds, int deb, int dec);
    drive(0, 0, 0, 1, s, leb, lec, ds, deb, dec);
  endtask

  task automatic check_one_word(string name, int mark, logic [31:0] d, int bc, bit last);
    check({name, "_count"}, lg_data.size(), mark + 1);
    if (lg_data.size() > mark) begin
      check({name, "_data"}, lg_data[mark], d);
      check({name, "_bytes"}, lg_bc[mark], bc);
      check({name, "_last"}, lg_last[mark], last);
    end
  endtask

  // Compare every emitted word against the model, in order
  always @(negedge clk) begin
    if (!rst && o_en) begin
      lg_data.push_back(o_data); lg_bc.push_back(int'(o_byte_cnt));
      lg_last.push_back(o_last); lg_cyc.push_back(cyc);
      if (ex_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got 0x%08h with no word expected", o_data);
      end else begin
        check("word_data", o_data, ex_data.pop_front());
        check("word_bytes", o_byte_cnt, ex_bc.pop_front());
        check("word_last", o_last, ex_last.pop_front());
      end
    end
  end

  int mark;
  int full_cnt;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", o_en, 0);
    check("rst_data", o_data, 0);
    check("rst_bytes", o_byte_cnt, 0);
    check("rst_last", o_last, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single final block with one literal
    mark = lg_data.size();
    start_blk(1); lit('h41); end_blk();
    idle(6);
    check_one_word("lit41", mark, 32'h00000473, 3, 1'b1);
    if (lg_cyc.size() > mark) check("flush_latency", lg_cyc[mark] - drv_cyc, 3);

    // Non-final block stays buffered; final block lands exactly on 32 bits
    mark = lg_data.size();
    start_blk(0); sym(257, 0, 0, 0, 0, 0); end_blk();
    idle(4);
    check("nonfinal_no_output", lg_data.size(), mark);
    start_blk(1); end_blk();
    idle(6);
    check_one_word("exact32", mark, 32'h00C00202, 4, 1'b1);
    if (lg_cyc.size() > mark) check("word_latency", lg_cyc[mark] - drv_cyc, 2);

    // 9-bit band boundaries
    mark = lg_data.size();
    start_blk(1); lit(144); lit(255); end_blk();
    idle(6);
    check_one_word("lit144_255", mark, 32'h001FF09B, 4, 1'b1);

    // Mixed symbols across band edges and extra-bit widths (model-checked)
    start_blk(1);
    lit(0); lit(143); lit(256 + 23);
    sym(265, 1, 1, 4, 1, 1);
    sym(280, 'hA, 4, 13, 'h1A, 5);
    sym(285, 0, 0, 27, 'hABC, 12);
    sym(257, 0, 0, 1, 0, 0);
    end_blk();
    idle(6);

    // Reset with 20 bits buffered discards them; new block starts at bit 0
    mark = lg_data.size();
    start_blk(0); lit(144); lit(0);
    idle(3);
    check("pre_reset_no_output", lg_data.size(), mark);
    @(posedge clk); #1 rst = 1'b1;
    bq.delete(); m_open = 0;
    check("pre_reset_pending", ex_data.size(), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_en", o_en, 0);
    mark = lg_data.size();
    start_blk(1); lit('h41); end_blk();
    idle(6);
    check_one_word("after_reset", mark, 32'h00000473, 3, 1'b1);

    // Symbol in IDLE dropped; start+symbol together gives header only
    mark = lg_data.size();
    lit('h41);
    idle(3);
    check("idle_symbol_dropped", lg_data.size(), mark);
    drive(1, 1, 0, 1, 'h55, 0, 0, 0, 0, 0);
    end_blk();
    idle(6);
    check_one_word("start_plus_sym", mark, 32'h00000003, 2, 1'b1);

    // 1000 back-to-back 30-bit chunks
    mark = lg_data.size();
    start_blk(1);
    repeat (1000) sym(284, 'h1F, 5, 27, 'hFFF, 12);
    end_blk();
    idle(8);
    check("max_total_words", lg_data.size() - mark, 938);
    full_cnt = 0;
    for (int i = mark; i < lg_data.size(); i++) if (!lg_last[i]) full_cnt++;
    check("max_full_words", full_cnt, 937);
    if (lg_data.size() > mark) begin
      check("max_final_bytes", lg_bc[lg_bc.size()-1], 4);
      check("max_final_last", lg_last[lg_last.size()-1], 1);
    end

    idle(10);
    check("leftover_expected", ex_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
